// File: rtl/sram_controller.sv
// sram_controller: splits one 32-bit big-endian word access from the MEM stage
// into two sequential 16-bit SRAM accesses (high half first, then low half),
// holding ready low so the pipeline stalls until the access completes.
module sram_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [31:0]        addr,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR_HI = 3'd1,
    WR_LO = 3'd2,
    RD_HI = 3'd3,
    RD_LO = 3'd4,
    DONE  = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        read_data_q, read_data_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]        dq_out_q, dq_out_d;
  logic               oe_q, oe_d;
  logic               we_n_q, we_n_d;

  logic [31:0]        offset;
  logic [SRAM_AW-1:0] hi_addr;
  logic [SRAM_AW-1:0] lo_addr;
  logic               phase_end;
  logic               unused_offset_bits;

  // Halfword addresses; bits above the SRAM width drop out so accesses wrap.
  assign offset             = addr - BASE_ADDR;
  assign hi_addr            = {offset[SRAM_AW:2], 1'b0};
  assign lo_addr            = {offset[SRAM_AW:2], 1'b1};
  assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  // Stall signal for the hazard unit; high when idle with no request or finishing.
  assign ready = ((state_q == IDLE) && !mem_read && !mem_write) || (state_q == DONE);

  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = oe_q;
  assign sram_we_n   = we_n_q;

  // Next-state, phase counter, read capture and SRAM pin values for the next state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    read_data_d = read_data_q;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    oe_d        = 1'b0;
    we_n_d      = 1'b1;
    phase_end   = (cnt_q == CNT_W'(WAIT_CYCLES));

    case (state_q)
      IDLE: begin
        if (mem_write) begin
          state_d = WR_HI;
        end else if (mem_read) begin
          state_d = RD_HI;
        end
      end
      WR_HI: if (phase_end) state_d = WR_LO;
      WR_LO: if (phase_end) state_d = DONE;
      RD_HI: begin
        if (phase_end) begin
          state_d             = RD_LO;
          read_data_d[31:16]  = sram_dq_in;
        end
      end
      RD_LO: begin
        if (phase_end) begin
          state_d            = DONE;
          read_data_d[15:0]  = sram_dq_in;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Counter only runs inside a phase and restarts on every state change.
    if ((state_d != state_q) || (state_q == IDLE) || (state_q == DONE)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Pins are registered, so they are loaded with the values of the state being entered.
    case (state_d)
      WR_HI: begin
        sram_addr_d = hi_addr;
        dq_out_d    = write_data[31:16];
        oe_d        = 1'b1;
        we_n_d      = 1'b0;
      end
      WR_LO: begin
        sram_addr_d = lo_addr;
        dq_out_d    = write_data[15:0];
        oe_d        = 1'b1;
        we_n_d      = 1'b0;
      end
      RD_HI:   sram_addr_d = hi_addr;
      RD_LO:   sram_addr_d = lo_addr;
      default: ;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      oe_q        <= 1'b0;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      read_data_q <= read_data_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      oe_q        <= oe_d;
      we_n_q      <= we_n_d;
    end
  end

endmodule
